// File: rtl/comparator_serial_if.sv
`default_nettype none
// ============================================================================
// Module  : comparator_serial_if
// Brief   : Operand/result handshake bundle for comparator_serial.
// Revision: 1.0
// ============================================================================
interface comparator_serial_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic         equals;
   logic         less_than;

   // Producer/consumer side that drives operands and drains results
   modport master (
      output in_valid,
      output a,
      output b,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  equals,
      input  less_than
   );

   // Comparator side
   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  out_ready,
      output in_ready,
      output out_valid,
      output equals,
      output less_than
   );
endinterface
`default_nettype wire

// File: rtl/comparator_serial.sv
`default_nettype none
// ============================================================================
// Module  : comparator_serial
// Brief   : Bit-serial MSB-first magnitude/equality comparator behind a
//           valid/ready handshake. Define COMPARATOR_SERIAL_EARLY_EXIT_EN to
//           finish on the first differing bit instead of scanning all N bits.
// Revision: 1.0
// ============================================================================
module comparator_serial #(
   parameter int N      = 32,
   parameter bit SIGNED = 1'b1
) (
   input  wire logic           clk,
   input  wire logic           rst,
   comparator_serial_if.slave  bus
);

   localparam int                IDX_W     = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] c_IDX_MSB = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] c_IDX_LSB = '0;

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_SCAN = 2'd1;
   localparam logic [1:0] c_S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_armed;
   logic [N-1:0]     r_a;
   logic [N-1:0]     r_b;
   logic [IDX_W-1:0] r_idx;
   logic             r_decided;
   logic             r_lt;
   logic             r_equals;
   logic             r_less_than;

   logic             w_accept;
   logic             w_bit_a;
   logic             w_bit_b;
   logic             w_diff;
   logic             w_signed_msb;
   logic             w_bit_lt;
   logic             w_decided_nxt;
   logic             w_lt_nxt;
   logic             w_scan_end;
   logic             w_in_ready;
   logic             w_out_valid;

   // ------------------------------------------------------------------------
   // Per-bit compare of the current scan position
   // ------------------------------------------------------------------------
   assign w_bit_a       = r_a[r_idx];
   assign w_bit_b       = r_b[r_idx];
   assign w_diff        = w_bit_a ^ w_bit_b;
   // In two's complement the sign bit carries negative weight, so its sense flips
   assign w_signed_msb  = SIGNED && (r_idx == c_IDX_MSB);
   assign w_bit_lt      = w_signed_msb ? (w_bit_a & ~w_bit_b) : (~w_bit_a & w_bit_b);
   assign w_decided_nxt = r_decided | w_diff;
   assign w_lt_nxt      = (w_diff && !r_decided) ? w_bit_lt : r_lt;

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
   assign w_scan_end = (r_idx == c_IDX_LSB) || w_diff;
`else
   assign w_scan_end = (r_idx == c_IDX_LSB);
`endif

   // r_armed keeps in_ready low until the first edge after reset releases
   assign w_accept = (r_state == c_S_IDLE) && r_armed && bus.in_valid;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: if (w_accept)      w_state_nxt = c_S_SCAN;
         c_S_SCAN: if (w_scan_end)    w_state_nxt = c_S_DONE;
         c_S_DONE: if (bus.out_ready) w_state_nxt = c_S_IDLE;
         default:                     w_state_nxt = c_S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_in_ready  = (r_state == c_S_IDLE) && r_armed;
      w_out_valid = (r_state == c_S_DONE);
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.equals    = r_equals;
   assign bus.less_than = r_less_than;

   // ------------------------------------------------------------------------
   // Operand, scan and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_idx       <= c_IDX_MSB;
         r_decided   <= 1'b0;
         r_lt        <= 1'b0;
         r_equals    <= 1'b0;
         r_less_than <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (w_accept) begin
            r_a       <= bus.a;
            r_b       <= bus.b;
            r_idx     <= c_IDX_MSB;
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
         end else if (r_state == c_S_SCAN) begin
            r_decided <= w_decided_nxt;
            r_lt      <= w_lt_nxt;
            if (w_scan_end) begin
               r_idx       <= c_IDX_MSB;
               r_equals    <= ~w_decided_nxt;
               r_less_than <= w_lt_nxt;
            end else begin
               r_idx <= r_idx - IDX_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------------
   a_never_eq_and_lt : assert property (
      @(posedge clk) disable iff (rst) !(r_equals && r_less_than));

   a_done_holds : assert property (
      @(posedge clk) disable iff (rst)
      (r_state == c_S_DONE && !bus.out_ready) |=>
         (r_state == c_S_DONE) && $stable({r_equals, r_less_than}));

endmodule
`default_nettype wire
